// File: rtl/mem_stage_sram.sv
// MEM stage: splits each 32-bit load/store into two 16-bit SRAM phases of WAIT_CYCLES each.
// Latency 2*WAIT_CYCLES+2 cycles per access; freeze holds the pipeline until the DONE cycle.
module mem_stage_sram #(
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        ST_value,
    input  logic [4:0]         Dest,
    input  logic               MEM_R_en,
    input  logic               MEM_W_en,
    input  logic               WB_en,
    output logic [31:0]        ALU_result_out,
    output logic [4:0]         Dest_out,
    output logic               WB_en_out,
    output logic               MEM_R_en_out,
    output logic [31:0]        MEM_result,
    output logic               freeze,
    output logic [SRAM_AW-1:0] SRAM_addr,
    output logic [15:0]        SRAM_wdata,
    input  logic [15:0]        SRAM_rdata,
    output logic               SRAM_we_n,
    output logic               SRAM_oe_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        st_q, st_d;
    logic               is_st_q, is_st_d;
    logic [31:0]        mem_result_q, mem_result_d;

    logic        req;
    logic        phase_last;
    logic [31:0] byte_off;
    logic        unused_off;

    assign req        = MEM_R_en | MEM_W_en;
    assign phase_last = (cnt_q == 4'(WAIT_CYCLES - 1));
    assign byte_off   = ALU_result - 32'(BASE_ADDR);
    // Bits outside the word index wrap away silently; the byte offset is ignored.
    assign unused_off = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

    assign ALU_result_out = ALU_result;
    assign Dest_out       = Dest;
    assign WB_en_out      = WB_en;
    assign MEM_R_en_out   = MEM_R_en;
    assign MEM_result     = mem_result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            st_q         <= '0;
            is_st_q      <= 1'b0;
            mem_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            st_q         <= st_d;
            is_st_q      <= is_st_d;
            mem_result_q <= mem_result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = LO;
            LO:      if (phase_last) state_d = HI;
            HI:      if (phase_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        word_d       = word_q;
        st_d         = st_q;
        is_st_d      = is_st_q;
        mem_result_d = mem_result_q;
        if (state_q == LO || state_q == HI)
            cnt_d = phase_last ? 4'd0 : cnt_q + 4'd1;
        if (state_q == IDLE && req) begin
            word_d  = byte_off[SRAM_AW:2];
            st_d    = ST_value;
            is_st_d = MEM_W_en;
        end
        // Read data is sampled only on the final cycle of each phase.
        if (!is_st_q && phase_last) begin
            if (state_q == LO) mem_result_d[15:0]  = SRAM_rdata;
            if (state_q == HI) mem_result_d[31:16] = SRAM_rdata;
        end
    end

    always_comb begin
        freeze     = req && (state_q != DONE);
        SRAM_addr  = '0;
        SRAM_wdata = '0;
        SRAM_we_n  = 1'b1;
        SRAM_oe_n  = 1'b1;
        if (state_q == LO || state_q == HI) begin
            SRAM_addr  = {word_q, state_q == HI};
            SRAM_wdata = (state_q == HI) ? st_q[31:16] : st_q[15:0];
            SRAM_we_n  = !is_st_q;
            SRAM_oe_n  = is_st_q;
        end
    end

endmodule
